// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, control-vector layout, ALU encodings and forwarding helpers
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 7;

    // Control vector {aluctrl[2:0], alusrc, regwrite, memread, memwrite}
    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_REGWRITE = 2;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALU_LSB  = 4;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_XOR = 3'b001,
        ALU_SLL = 3'b010,
        ALU_ADD = 3'b011,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SRA = 3'b110
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        FWD_REG,
        FWD_MEMWB,
        FWD_EXMEM
    } fwd_sel_e;

    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1_addr;
        logic [REG_AW-1:0] rs2_addr;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

    // The youngest producer (EX/MEM) wins; x0 is never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic              exmem_regwrite,
        input logic [REG_AW-1:0] exmem_rd,
        input logic              memwb_regwrite,
        input logic [REG_AW-1:0] memwb_rd,
        input logic [REG_AW-1:0] rs
    );
        return (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
               (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_REG;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode inputs, write-back forwarding info and EX-stage outputs of the ID/EX register
interface id_ex_stage_if;
    import cpu_pkg::*;

    logic              id_valid_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [REG_AW-1:0] id_rs1_addr_i;
    logic [REG_AW-1:0] id_rs2_addr_i;
    logic [REG_AW-1:0] id_rd_addr_i;
    logic [CTRL_W-1:0] id_ctrl_i;
    logic              stall_i;
    logic              flush_i;
    logic              exmem_regwrite_i;
    logic [REG_AW-1:0] exmem_rd_i;
    logic [XLEN-1:0]   exmem_result_i;
    logic              memwb_regwrite_i;
    logic [REG_AW-1:0] memwb_rd_i;
    logic [XLEN-1:0]   memwb_result_i;
    logic              hazard_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   alu_data1_o;
    logic [XLEN-1:0]   alu_data2_o;
    logic [2:0]        alu_ctrl_o;
    logic [XLEN-1:0]   store_data_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_regwrite_o;
    logic              ex_memread_o;
    logic              ex_memwrite_o;

    modport master (
        output id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i,
               stall_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_result_i,
        input  hazard_o, ex_valid_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
               store_data_o, ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o
    );

    modport slave (
        input  id_valid_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i, id_ctrl_i,
               stall_i, flush_i,
               exmem_regwrite_i, exmem_rd_i, exmem_result_i,
               memwb_regwrite_i, memwb_rd_i, memwb_result_i,
        output hazard_o, ex_valid_o, alu_data1_o, alu_data2_o, alu_ctrl_o,
               store_data_o, ex_rd_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o
    );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// forward_unit: picks the operand source for the two EX-stage register reads
module forward_unit
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    output fwd_sel_e          sel1,
    output fwd_sel_e          sel2
);

    // Same producer-priority rule applied independently to each operand
    always_comb begin
        sel1 = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, rs1);
        sel2 = fwd_select(exmem_regwrite, exmem_rd, memwb_regwrite, memwb_rd, rs2);
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion and EX operand forwarding
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    id_ex_stage_if.slave  bus
);

    id_ex_t          ex_q;
    fwd_sel_e        sel1;
    fwd_sel_e        sel2;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            hazard;

    // A load in EX whose destination is read by the instruction in ID needs one bubble
    always_comb begin
        hazard = bus.id_valid_i && ex_q.valid && ex_q.ctrl[CTRL_MEMREAD] && ex_q.rd != '0 &&
                 (ex_q.rd == bus.id_rs1_addr_i || ex_q.rd == bus.id_rs2_addr_i) &&
                 !bus.flush_i && !bus.stall_i;
    end

    forward_unit u_fwd (
        .rs1            (ex_q.rs1_addr),
        .rs2            (ex_q.rs2_addr),
        .exmem_regwrite (bus.exmem_regwrite_i),
        .exmem_rd       (bus.exmem_rd_i),
        .memwb_regwrite (bus.memwb_regwrite_i),
        .memwb_rd       (bus.memwb_rd_i),
        .sel1           (sel1),
        .sel2           (sel2)
    );

    // Operand muxes driven by the forwarding selects
    always_comb begin
        fwd_rs1 = sel1 == FWD_EXMEM ? bus.exmem_result_i :
                  sel1 == FWD_MEMWB ? bus.memwb_result_i : ex_q.rs1_data;
        fwd_rs2 = sel2 == FWD_EXMEM ? bus.exmem_result_i :
                  sel2 == FWD_MEMWB ? bus.memwb_result_i : ex_q.rs2_data;
    end

    // Pipeline register: flush and load-use bubble clear, stall holds, otherwise capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_q <= '0;
        end else if (bus.flush_i || hazard) begin
            ex_q <= '0;
        end else if (!bus.stall_i) begin
            ex_q <= '{
                valid:    bus.id_valid_i,
                ctrl:     bus.id_valid_i ? bus.id_ctrl_i : '0,
                rs1_data: bus.id_rs1_data_i,
                rs2_data: bus.id_rs2_data_i,
                imm:      bus.id_imm_i,
                rs1_addr: bus.id_rs1_addr_i,
                rs2_addr: bus.id_rs2_addr_i,
                rd:       bus.id_rd_addr_i
            };
        end
    end

    assign bus.hazard_o      = hazard;
    assign bus.ex_valid_o    = ex_q.valid;
    assign bus.alu_data1_o   = fwd_rs1;
    assign bus.alu_data2_o   = ex_q.ctrl[CTRL_ALUSRC] ? ex_q.imm : fwd_rs2;
    assign bus.alu_ctrl_o    = ex_q.ctrl[CTRL_ALU_LSB +: 3];
    assign bus.store_data_o  = fwd_rs2;
    assign bus.ex_rd_o       = ex_q.rd;
    assign bus.ex_regwrite_o = ex_q.ctrl[CTRL_REGWRITE];
    assign bus.ex_memread_o  = ex_q.ctrl[CTRL_MEMREAD];
    assign bus.ex_memwrite_o = ex_q.ctrl[CTRL_MEMWRITE];

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a behavioural model
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // What the model believes the EX stage currently holds
    typedef struct packed {
        bit          valid;
        logic [2:0]  op;
        bit          use_imm;
        bit          writes_reg;
        bit          is_load;
        bit          is_store;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
    } ex_t;

    ex_t m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value an instruction in EX sees for register ra, given what is in flight downstream
    function automatic logic [31:0] operand(input logic [4:0] ra, input logic [31:0] file_val);
        if (ra == 5'd0) return file_val;
        if (bus.exmem_regwrite_i && bus.exmem_rd_i == ra) return bus.exmem_result_i;
        if (bus.memwb_regwrite_i && bus.memwb_rd_i == ra) return bus.memwb_result_i;
        return file_val;
    endfunction

    function automatic bit load_use();
        bit reads_loaded = (m.rd == bus.id_rs1_addr_i) || (m.rd == bus.id_rs2_addr_i);
        return bus.id_valid_i && m.valid && m.is_load && m.rd != 5'd0 && reads_loaded &&
               !bus.flush_i && !bus.stall_i;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else if (bus.flush_i) m <= '0;
        else if (bus.stall_i) m <= m;
        else if (load_use()) m <= '0;
        else begin
            m.valid      <= bus.id_valid_i;
            m.op         <= bus.id_valid_i ? bus.id_ctrl_i[6:4] : 3'd0;
            m.use_imm    <= bus.id_valid_i & bus.id_ctrl_i[3];
            m.writes_reg <= bus.id_valid_i & bus.id_ctrl_i[2];
            m.is_load    <= bus.id_valid_i & bus.id_ctrl_i[1];
            m.is_store   <= bus.id_valid_i & bus.id_ctrl_i[0];
            m.a          <= bus.id_rs1_data_i;
            m.b          <= bus.id_rs2_data_i;
            m.imm        <= bus.id_imm_i;
            m.ra         <= bus.id_rs1_addr_i;
            m.rb         <= bus.id_rs2_addr_i;
            m.rd         <= bus.id_rd_addr_i;
        end
    end

    task automatic check_outputs(input string tag);
        logic [31:0] b = operand(m.rb, m.b);
        chk({tag, ".hazard"}, 32'(bus.hazard_o), 32'(load_use()));
        chk({tag, ".valid"}, 32'(bus.ex_valid_o), 32'(m.valid));
        chk({tag, ".data1"}, bus.alu_data1_o, operand(m.ra, m.a));
        chk({tag, ".data2"}, bus.alu_data2_o, m.use_imm ? m.imm : b);
        chk({tag, ".aluctrl"}, 32'(bus.alu_ctrl_o), 32'(m.op));
        chk({tag, ".store"}, bus.store_data_o, b);
        chk({tag, ".rd"}, 32'(bus.ex_rd_o), 32'(m.rd));
        chk({tag, ".regwrite"}, 32'(bus.ex_regwrite_o), 32'(m.writes_reg));
        chk({tag, ".memread"}, 32'(bus.ex_memread_o), 32'(m.is_load));
        chk({tag, ".memwrite"}, 32'(bus.ex_memwrite_o), 32'(m.is_store));
    endtask

    function automatic logic [6:0] mk(input alu_ctrl_e op, input bit src, input bit rw, input bit mr, input bit mw);
        return {op, src, rw, mr, mw};
    endfunction

    task automatic drive_id(input bit v, input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                            input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd, input logic [6:0] ctrl);
        bus.id_valid_i    = v;
        bus.id_rs1_data_i = a;
        bus.id_rs2_data_i = b;
        bus.id_imm_i      = imm;
        bus.id_rs1_addr_i = ra;
        bus.id_rs2_addr_i = rb;
        bus.id_rd_addr_i  = rd;
        bus.id_ctrl_i     = ctrl;
    endtask

    task automatic drive_wb(input bit erw, input logic [4:0] erd, input logic [31:0] eres,
                            input bit mrw, input logic [4:0] mrd, input logic [31:0] mres);
        bus.exmem_regwrite_i = erw;
        bus.exmem_rd_i       = erd;
        bus.exmem_result_i   = eres;
        bus.memwb_regwrite_i = mrw;
        bus.memwb_rd_i       = mrd;
        bus.memwb_result_i   = mres;
    endtask

    task automatic step(input string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        drive_id(1'b1, 32'h55, 32'h66, 32'h77, 5'd1, 5'd2, 5'd3, mk(ALU_SUB, 1, 1, 1, 1));
        drive_wb(0, 0, 0, 0, 0, 0);
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        step("reset");
        chk("reset.valid0", 32'(bus.ex_valid_o), 32'd0);
        rst_n = 1'b1;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        step("post_reset");
        chk("post_reset.valid", 32'(bus.ex_valid_o), 32'd0);

        // Capture rs1=5, rs2=-3 as an ADD
        drive_id(1, 32'h5, 32'hFFFF_FFFD, 32'h0, 5'd1, 5'd2, 5'd4, mk(ALU_ADD, 0, 1, 0, 0));
        step("cap0");
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("cap.data1", bus.alu_data1_o, 32'h5);
        chk("cap.data2", bus.alu_data2_o, 32'hFFFF_FFFD);
        chk("cap.aluctrl", 32'(bus.alu_ctrl_o), 32'b011);
        step("cap1");

        // Forwarding priority on rs1=x7, and rs2=x0 never forwarded
        drive_id(1, 32'h11, 32'h22, 0, 5'd7, 5'd0, 5'd9, mk(ALU_ADD, 0, 1, 0, 0));
        step("fwd0");
        bus.stall_i = 1'b1;
        drive_wb(1, 5'd7, 32'hAA, 1, 5'd7, 32'hBB);
        #1 chk("fwd.exmem", bus.alu_data1_o, 32'hAA);
        bus.exmem_regwrite_i = 1'b0;
        #1 chk("fwd.memwb", bus.alu_data1_o, 32'hBB);
        drive_wb(1, 5'd0, 32'hCC, 1, 5'd0, 32'hDD);
        #1 chk("fwd.x0_rs1", bus.alu_data1_o, 32'h11);
        chk("fwd.x0_rs2", bus.store_data_o, 32'h22);
        step("fwd1");
        bus.stall_i = 1'b0;
        drive_wb(0, 0, 0, 0, 0, 0);

        // Load-use: lw x3 in EX, add x4,x3,x1 in ID
        drive_id(1, 32'h1000, 0, 32'h8, 5'd2, 5'd0, 5'd3, mk(ALU_ADD, 1, 1, 1, 0));
        step("lw");
        drive_id(1, 32'h100, 32'h200, 0, 5'd3, 5'd1, 5'd4, mk(ALU_ADD, 0, 1, 0, 0));
        #1 chk("lu.hazard", 32'(bus.hazard_o), 32'd1);
        step("lu0");
        #1 chk("lu.bubble", 32'(bus.ex_valid_o), 32'd0);
        chk("lu.once", 32'(bus.hazard_o), 32'd0);
        step("lu1");
        drive_wb(0, 0, 0, 1, 5'd3, 32'h77);
        #1 chk("lu.valid", 32'(bus.ex_valid_o), 32'd1);
        chk("lu.fwd_x3", bus.alu_data1_o, 32'h77);
        chk("lu.x1", bus.alu_data2_o, 32'h200);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        step("lu2");
        drive_wb(0, 0, 0, 0, 0, 0);

        // Stall freezes a load while ID would otherwise trigger a bubble; flush beats stall
        drive_id(1, 32'hA, 32'hB, 32'h4, 5'd1, 5'd2, 5'd3, mk(ALU_AND, 1, 1, 1, 0));
        step("st0");
        bus.stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1, 32'(i), 32'(i + 9), 0, 5'd3, 5'd3, 5'd5, mk(ALU_XOR, 0, 1, 0, 1));
            #1;
            chk("stall.hazard", 32'(bus.hazard_o), 32'd0);
            chk("stall.rd", 32'(bus.ex_rd_o), 32'd3);
            chk("stall.data1", bus.alu_data1_o, 32'hA);
            step("stall");
        end
        bus.flush_i = 1'b1;
        step("flush");
        chk("flush.valid", 32'(bus.ex_valid_o), 32'd0);
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;

        // Immediate path while rs2 is forwarded to the store data
        drive_id(1, 32'h1, 32'h2, 32'hFFFF_F800, 5'd0, 5'd5, 5'd6, mk(ALU_ADD, 1, 0, 0, 1));
        step("imm0");
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
        drive_wb(1, 5'd5, 32'h12, 0, 0, 0);
        #1 chk("imm.data2", bus.alu_data2_o, 32'hFFFF_F800);
        chk("imm.store", bus.store_data_o, 32'h12);
        step("imm1");

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            drive_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 7'($urandom));
            drive_wb($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
            bus.stall_i = $urandom_range(0, 7) == 0;
            bus.flush_i = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1 check_outputs("arst");
                chk("arst.valid", 32'(bus.ex_valid_o), 32'd0);
                rst_n = 1'b1;
            end
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
